lc3_fetch_unit: RTL and testbench

//  PC register plus instruction-fetch sequencer for the simplified LC-3 datapath.

---
 rtl/lc3_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_lc3_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_fetch_unit
//  Purpose  : PC register and instruction-fetch sequencer for the simplified
//             LC-3 datapath. Registers the PC select mux output on ld_pc,
//             feeds pc+1 back to the mux, and on fetch_req issues one memory
//             read at PC, latches the returned word into IR and advances PC.
//  Ports    : Clk, Reset (async, active-high)
//             fetch_req, ld_pc, pc_mux_in     - control / next-PC from mux
//             mem_ready, mem_rdata            - memory read response
//             mem_req, mem_addr               - memory read request / MAR
//             pc, pc_plus1, ir, ir_valid      - architectural state
//             fetch_busy, fetch_done, fetch_err - sequencer status
//  Config   : `define FETCH_TIMEOUT_EN to abort a FETCH after TIMEOUT_CYCLES
//             consecutive cycles without mem_ready (fetch_err pulses).
//             Without it FETCH waits indefinitely and fetch_err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module lc3_fetch_unit #(
    parameter int               WIDTH          = 16,
    parameter logic [WIDTH-1:0] RESET_PC       = 16'h3000,
    parameter int               TIMEOUT_CYCLES = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             fetch_req,
    input  logic             ld_pc,
    input  logic [WIDTH-1:0] pc_mux_in,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus1,
    output logic [WIDTH-1:0] ir,
    output logic             ir_valid,
    output logic             fetch_busy,
    output logic             fetch_done,
    output logic             fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   timeout;

    // Wraps modulo 2^WIDTH; no carry is exported.
    assign pc_plus1   = pc + {{(WIDTH-1){1'b0}}, 1'b1};

    // Status outputs decode straight from the state register so that an
    // asynchronous reset drops mem_req without waiting for a clock edge.
    assign mem_req    = (state == S_FETCH);
    assign fetch_done = (state == S_DONE);
    assign fetch_busy = (state == S_FETCH) || (state == S_DONE);

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_pulse;

    // mem_ready on the expiry edge wins, hence the !mem_ready term.
    assign timeout   = (state == S_FETCH) && !mem_ready && (wait_cnt == CNT_LAST);
    assign fetch_err = err_pulse;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wait_cnt  <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= timeout;
            // Held at zero outside FETCH so every FETCH entry starts fresh.
            if (state != S_FETCH) begin
                wait_cnt <= '0;
            end else if (!mem_ready && !timeout) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (fetch_req) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    next_state = S_DONE;
                end else if (timeout) begin
                    next_state = S_IDLE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: PC, MAR, IR
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc       <= RESET_PC;
            mem_addr <= RESET_PC;
            ir       <= '0;
            ir_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ld_pc) begin
                        pc <= pc_mux_in;
                    end
                    if (fetch_req) begin
                        // A simultaneous ld_pc redirects this fetch.
                        mem_addr <= ld_pc ? pc_mux_in : pc;
                        ir_valid <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        ir       <= mem_rdata;
                        pc       <= pc_plus1;
                        ir_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lc3_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lc3_fetch_unit
//  Purpose  : Self-checking bench for lc3_fetch_unit. Each fetch pushes its
//             expected IR/PC into a scoreboard; entries are popped and
//             compared whenever the DUT pulses fetch_done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_fetch_unit;

    localparam int WIDTH = 16;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             fetch_req;
    logic             ld_pc;
    logic [WIDTH-1:0] pc_mux_in;
    logic             mem_ready;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] ir;
    logic             ir_valid;
    logic             fetch_busy;
    logic             fetch_done;
    logic             fetch_err;

    int errors = 0;
    int checks = 0;
    int done_pulses = 0;

    typedef struct packed {
        logic [WIDTH-1:0] ir;
        logic [WIDTH-1:0] pc;
    } exp_t;
    exp_t sb[$];

    lc3_fetch_unit #(
        .WIDTH          (WIDTH),
        .RESET_PC       (16'h3000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .fetch_req  (fetch_req),
        .ld_pc      (ld_pc),
        .pc_mux_in  (pc_mux_in),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .pc         (pc),
        .pc_plus1   (pc_plus1),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .fetch_busy (fetch_busy),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard consumer: one entry per fetch_done pulse.
    always @(negedge Clk) begin
        if (!Reset && fetch_done) begin
            exp_t e;
            done_pulses++;
            if (sb.size() == 0) begin
                chk("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_ir", 32'(ir), 32'(e.ir));
                chk("sb_pc", 32'(pc), 32'(e.pc));
                chk("sb_ir_valid", 32'(ir_valid), 32'd1);
            end
        end
    end

    // Start a fetch from IDLE, hold mem_ready low for 'waits' FETCH cycles
    // (pulsing ignored controls meanwhile), then complete it.
    task automatic do_fetch(input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] rdata,
                            input logic ld, input logic [WIDTH-1:0] mux, input int waits);
        exp_t e;
        e.ir = rdata;
        e.pc = addr + 16'd1;
        sb.push_back(e);
        fetch_req = 1'b1;
        ld_pc     = ld;
        pc_mux_in = mux;
        mem_rdata = rdata;
        mem_ready = 1'b0;
        step();
        fetch_req = 1'b0;
        ld_pc     = 1'b0;
        chk("fetch_mem_req", 32'(mem_req), 32'd1);
        chk("fetch_mem_addr", 32'(mem_addr), 32'(addr));
        chk("fetch_ir_valid_clr", 32'(ir_valid), 32'd0);
        chk("fetch_busy", 32'(fetch_busy), 32'd1);
        for (int i = 0; i < waits; i++) begin
            fetch_req = i[0];
            ld_pc     = ~i[0];
            pc_mux_in = 16'hDEAD;
            step();
            chk("wait_mem_req", 32'(mem_req), 32'd1);
            chk("wait_mem_addr", 32'(mem_addr), 32'(addr));
            chk("wait_pc_hold", 32'(pc), 32'(ld ? mux : addr));
        end
        fetch_req = 1'b0;
        ld_pc     = 1'b0;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("done_pulse", 32'(fetch_done), 32'd1);
        chk("done_mem_req", 32'(mem_req), 32'd0);
        step();
        chk("done_cleared", 32'(fetch_done), 32'd0);
        chk("idle_busy", 32'(fetch_busy), 32'd0);
    endtask

    initial begin
        Reset     = 1'b1;
        fetch_req = 1'b0;
        ld_pc     = 1'b0;
        pc_mux_in = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_pc", 32'(pc), 32'h3000);
        chk("rst_mem_addr", 32'(mem_addr), 32'h3000);
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_done", 32'(fetch_done), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        step();

        // Reset abandoning an in-flight fetch
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("midfetch_mem_req", 32'(mem_req), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_mem_req_drop", 32'(mem_req), 32'd0);
        chk("async_pc", 32'(pc), 32'h3000);
        chk("async_ir_valid", 32'(ir_valid), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        step();
        chk("post_rst_idle", 32'(fetch_busy), 32'd0);
        chk("post_rst_ir", 32'(ir), 32'h0);

        // Basic fetch at reset PC
        do_fetch(16'h3000, 16'h1234, 1'b0, 16'h0000, 0);
        chk("t2_ir", 32'(ir), 32'h1234);
        chk("t2_pc", 32'(pc), 32'h3001);
        chk("t2_ir_valid", 32'(ir_valid), 32'd1);

        // ld_pc together with fetch_req
        do_fetch(16'h4000, 16'hABCD, 1'b1, 16'h4000, 0);
        chk("t3_pc", 32'(pc), 32'h4001);

        // PC wrap at FFFF
        ld_pc     = 1'b1;
        pc_mux_in = 16'hFFFF;
        step();
        ld_pc = 1'b0;
        chk("t4_pc_load", 32'(pc), 32'hFFFF);
        chk("t4_plus1_wrap", 32'(pc_plus1), 32'h0000);
        do_fetch(16'hFFFF, 16'h5A5A, 1'b0, 16'h0000, 0);
        chk("t4_pc", 32'(pc), 32'h0000);
        chk("t4_plus1", 32'(pc_plus1), 32'h0001);

        // Five wait cycles with ignored controls
        do_fetch(16'h0000, 16'h0F0F, 1'b0, 16'h0000, 5);
        chk("t5_pc", 32'(pc), 32'h0001);
        chk("t5_ir", 32'(ir), 32'h0F0F);

        // Back-to-back with a fresh ld_pc redirect
        do_fetch(16'h1234, 16'hC3C3, 1'b1, 16'h1234, 2);

`ifdef FETCH_TIMEOUT_EN
        begin
            logic [WIDTH-1:0] pc_before;
            pc_before = pc;
            fetch_req = 1'b1;
            step();
            fetch_req = 1'b0;
            for (int i = 1; i < 16; i++) begin
                step();
                chk("to_no_err_early", 32'(fetch_err), 32'd0);
            end
            step();
            chk("to_err_pulse", 32'(fetch_err), 32'd1);
            chk("to_idle", 32'(mem_req), 32'd0);
            chk("to_pc", 32'(pc), 32'(pc_before));
            chk("to_ir_valid", 32'(ir_valid), 32'd0);
            step();
            chk("to_err_clear", 32'(fetch_err), 32'd0);
        end
`else
        chk("err_tied_low", 32'(fetch_err), 32'd0);
`endif

        step();
        chk("done_pulse_count", 32'(done_pulses), 32'd5);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
